// File: rtl/c2f_rng_checker.sv
// c2f_rng_checker
//   Consumer for the CPU->FPGA burst pipe. Drains chunks from the C2F chunk
//   RAM, compares every QW against a locally regenerated 64-bit Galois LFSR
//   sequence, counts mismatches and releases each chunk back to the
//   transceiver with a one-cycle dtAck_out pulse.
//
// Optional feature: define C2F_CHECKER_STOP_ON_ERR_EN to freeze the checker in
//   S_HALT on the first mismatch, leaving the failing chunk/offset visible.
//
// Ports:
//   pcieClk_in      clock (125 MHz PCIe)
//   pcieRstN_in     asynchronous active-low reset
//   wrPtr_in        producer write pointer (next chunk to be filled)
//   rdPtr_out       chunk being checked / next to check
//   rdOffset_out    QW read address within the chunk
//   rdData_in       RAM read data, 1-cycle registered latency
//   dtAck_out       one-cycle pulse when a chunk is released
//   enable_in       permits starting a new chunk
//   resync_in       sync reload of LFSR from seed_in, clears pointer/counters
//   seed_in         LFSR seed (zero is replaced by 1)
//   errCount_out    saturating mismatch count
//   chunkCount_out  released-chunk count (wraps)
//   errFlag_out     sticky mismatch flag
//   busy_out        high whenever the FSM is not idle
module c2f_rng_checker #(
  parameter int PTR_NBITS    = 2,
  parameter int OFFSET_NBITS = 9
) (
  input  logic                    pcieClk_in,
  input  logic                    pcieRstN_in,
  input  logic [PTR_NBITS-1:0]    wrPtr_in,
  output logic [PTR_NBITS-1:0]    rdPtr_out,
  output logic [OFFSET_NBITS-1:0] rdOffset_out,
  input  logic [63:0]             rdData_in,
  output logic                    dtAck_out,
  input  logic                    enable_in,
  input  logic                    resync_in,
  input  logic [63:0]             seed_in,
  output logic [15:0]             errCount_out,
  output logic [31:0]             chunkCount_out,
  output logic                    errFlag_out,
  output logic                    busy_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
`ifdef C2F_CHECKER_STOP_ON_ERR_EN
  localparam logic [1:0] S_HALT    = 2'd3;
`endif

  localparam logic [63:0]             LFSR_TAPS   = 64'hD800_0000_0000_0000;
  localparam logic [OFFSET_NBITS-1:0] OFFSET_LAST = '1;

  logic [1:0]  state;
  logic [63:0] lfsr;
  logic [63:0] lfsrNext;
  // vldPipe[0]: an address is being issued this cycle
  // vldPipe[1]: rdData_in holds the data for last cycle's address
  logic [1:0]  vldPipe;
  logic        lastCmp;   // qualifies vldPipe[1] as the compare of offset all-ones
  logic        mismatch;

  assign lfsrNext  = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? LFSR_TAPS : 64'd0);
  assign mismatch  = vldPipe[1] && (rdData_in != lfsr);
  assign dtAck_out = (state == S_RELEASE);
  assign busy_out  = (state != S_IDLE);

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state          <= S_IDLE;
      lfsr           <= 64'h1;
      vldPipe        <= '0;
      lastCmp        <= 1'b0;
      rdPtr_out      <= '0;
      rdOffset_out   <= '0;
      errCount_out   <= '0;
      chunkCount_out <= '0;
      errFlag_out    <= 1'b0;
    end else if (resync_in) begin
      state          <= S_IDLE;
      lfsr           <= (seed_in == 64'd0) ? 64'h1 : seed_in;
      vldPipe        <= '0;
      lastCmp        <= 1'b0;
      rdPtr_out      <= '0;
      rdOffset_out   <= '0;
      errCount_out   <= '0;
      chunkCount_out <= '0;
      errFlag_out    <= 1'b0;
    end else begin
      // Compare datapath: the LFSR steps once per compared QW, so the
      // sequence runs continuously across chunk boundaries.
      if (vldPipe[1]) lfsr <= lfsrNext;
      if (mismatch) begin
        if (errCount_out != 16'hFFFF) errCount_out <= errCount_out + 16'd1;
        errFlag_out <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          // wrPtr_in is only looked at here, so producer moves mid-chunk are
          // deferred until the current chunk is released.
          if (enable_in && (rdPtr_out != wrPtr_in)) begin
            state        <= S_CHECK;
            rdOffset_out <= '0;
            vldPipe[0]   <= 1'b1;
          end
        end
        S_CHECK: begin
          vldPipe[1] <= vldPipe[0];
          lastCmp    <= vldPipe[0] && (rdOffset_out == OFFSET_LAST);
          if (vldPipe[0]) begin
            if (rdOffset_out == OFFSET_LAST) vldPipe[0]   <= 1'b0;
            else                             rdOffset_out <= rdOffset_out + OFFSET_NBITS'(1);
          end
          if (lastCmp) state <= S_RELEASE;
`ifdef C2F_CHECKER_STOP_ON_ERR_EN
          // Freeze on the first bad QW; overrides the release transition too.
          if (mismatch) begin
            state        <= S_HALT;
            vldPipe      <= '0;
            lastCmp      <= 1'b0;
            rdOffset_out <= rdOffset_out;
          end
`else
          // Mismatches are only counted; checking carries on.
`endif
        end
        S_RELEASE: begin
          rdPtr_out      <= rdPtr_out + PTR_NBITS'(1);
          chunkCount_out <= chunkCount_out + 32'd1;
          state          <= S_IDLE;
        end
`ifdef C2F_CHECKER_STOP_ON_ERR_EN
        S_HALT: begin
          state <= S_HALT;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c2f_rng_checker.sv
// Scoreboard bench for c2f_rng_checker (default build). The main process
// fills chunks of a behavioural RAM from a model LFSR, optionally corrupting
// QWs, and pushes the expected release record; a monitor pops and compares on
// every dtAck_out pulse.
module tb_c2f_rng_checker;
  localparam int PTR_NBITS    = 2;
  localparam int OFFSET_NBITS = 9;
  localparam int NQW          = 1 << OFFSET_NBITS;
  localparam int NCHUNK       = 1 << PTR_NBITS;

  logic                    pcieClk_in = 1'b0;
  logic                    pcieRstN_in;
  logic [PTR_NBITS-1:0]    wrPtr_in;
  logic [PTR_NBITS-1:0]    rdPtr_out;
  logic [OFFSET_NBITS-1:0] rdOffset_out;
  logic [63:0]             rdData_in;
  logic                    dtAck_out;
  logic                    enable_in;
  logic                    resync_in;
  logic [63:0]             seed_in;
  logic [15:0]             errCount_out;
  logic [31:0]             chunkCount_out;
  logic                    errFlag_out;
  logic                    busy_out;

  always #5 pcieClk_in = ~pcieClk_in;

  c2f_rng_checker #(.PTR_NBITS(PTR_NBITS), .OFFSET_NBITS(OFFSET_NBITS)) dut (
    .pcieClk_in(pcieClk_in), .pcieRstN_in(pcieRstN_in),
    .wrPtr_in(wrPtr_in), .rdPtr_out(rdPtr_out), .rdOffset_out(rdOffset_out),
    .rdData_in(rdData_in), .dtAck_out(dtAck_out), .enable_in(enable_in),
    .resync_in(resync_in), .seed_in(seed_in), .errCount_out(errCount_out),
    .chunkCount_out(chunkCount_out), .errFlag_out(errFlag_out), .busy_out(busy_out)
  );

  // Chunk RAM with registered 1-cycle read.
  logic [63:0] ram [NCHUNK][NQW];
  always @(posedge pcieClk_in) rdData_in <= ram[rdPtr_out][rdOffset_out];

  typedef struct { int ptr; int cnt; int err; } exp_t;
  exp_t sb[$];

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int riseCyc = 0;
  logic busyPrev = 1'b0;

  // Reference model state
  logic [63:0] prodLfsr;
  int errTotal, chunksSent, wrPtrM;

  function automatic logic [63:0] modelNext(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'd0);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    nChecks++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every release must match the oldest outstanding chunk.
  always @(negedge pcieClk_in) begin : mon
    exp_t e;
    cyc++;
    if (pcieRstN_in) begin
      if (busy_out && !busyPrev) riseCyc = cyc;
      if (dtAck_out) begin
        if (sb.size() == 0) failNow("spurious_ack: dtAck with nothing outstanding");
        else begin
          e = sb.pop_front();
          check("ack_rdPtr", rdPtr_out, e.ptr);
          check("ack_chunkCount", chunkCount_out, e.cnt);
          check("ack_errCount", errCount_out, e.err);
          check("ack_errFlag", errFlag_out, e.err != 0);
          // busy rises one cycle after detect, so detect->ack = this + 1
          check("ack_latency", cyc - riseCyc + 1, NQW + 2);
        end
      end
    end
    busyPrev = busy_out;
  end

  task automatic tick();
    @(posedge pcieClk_in); #1;
  endtask

  // mode 0 clean, 1 QW37^1, 2 sparse random corruption, 3 every QW corrupted
  task automatic sendChunk(input int mode);
    int k = 0;
    int t = 0;
    logic [63:0] v;
    while (sb.size() >= 3 && t < 5000) begin tick(); t++; end
    if (t >= 5000) failNow("timeout waiting for ring space");
    for (int i = 0; i < NQW; i++) begin
      v = prodLfsr;
      if (mode == 1 && i == 37) begin v = v ^ 64'h1; k++; end
      if (mode == 2 && $urandom_range(0, 199) == 0) begin
        v = v ^ ({32'($urandom), 32'($urandom)} | 64'h1); k++;
      end
      if (mode == 3) begin v = ~v; k++; end
      ram[wrPtrM][i] = v;
      prodLfsr = modelNext(prodLfsr);
    end
    errTotal = (errTotal + k > 65535) ? 65535 : errTotal + k;
    sb.push_back('{wrPtrM, chunksSent, errTotal});
    chunksSent++;
    wrPtrM = (wrPtrM + 1) % NCHUNK;
    wrPtr_in = PTR_NBITS'(wrPtrM);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || busy_out) && t < 3000) begin tick(); t++; end
    if (t >= 3000) failNow("timeout draining chunks");
    tick();
  endtask

  task automatic waitOffset(input int off);
    int t = 0;
    while (rdOffset_out != OFFSET_NBITS'(off) && t < 2000) begin tick(); t++; end
    if (t >= 2000) failNow("timeout waiting for offset");
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_rdPtr"}, rdPtr_out, 0);
    check({tag, "_rdOffset"}, rdOffset_out, 0);
    check({tag, "_dtAck"}, dtAck_out, 0);
    check({tag, "_errCount"}, errCount_out, 0);
    check({tag, "_chunkCount"}, chunkCount_out, 0);
    check({tag, "_errFlag"}, errFlag_out, 0);
    check({tag, "_busy"}, busy_out, 0);
  endtask

  task automatic modelClear(input logic [63:0] seed);
    sb.delete();
    prodLfsr = (seed == 64'd0) ? 64'h1 : seed;
    errTotal = 0; chunksSent = 0; wrPtrM = 0;
  endtask

  // Called aligned at posedge+1.
  task automatic doResync(input logic [63:0] seed);
    modelClear(seed);
    seed_in = seed; resync_in = 1'b1; wrPtr_in = '0;
    tick();
    resync_in = 1'b0;
    checkIdle("resync");
  endtask

  task automatic checkTotals(input string tag);
    check({tag, "_rdPtr"}, rdPtr_out, wrPtrM);
    check({tag, "_chunkCount"}, chunkCount_out, chunksSent);
    check({tag, "_errCount"}, errCount_out, errTotal);
  endtask

  initial begin
    pcieRstN_in = 1'b0; wrPtr_in = '0; enable_in = 1'b0; resync_in = 1'b0;
    seed_in = {32'($urandom), 32'($urandom)};
    modelClear(64'h1);   // reset does not sample seed_in
    #12 checkIdle("reset");
    #10 pcieRstN_in = 1'b1;
    tick();
    enable_in = 1'b1;

    // Clean chunk, single corruption, then ring wrap (5 chunks total).
    sendChunk(0);
    sendChunk(1);
    for (int i = 0; i < 3; i++) sendChunk(0);
    drain();
    checkTotals("ring");
    check("ring_errFlag", errFlag_out, 1);

    // Random sparse corruption.
    for (int i = 0; i < 3; i++) sendChunk(2);
    drain();
    checkTotals("random");

    // enable_in dropped mid-chunk: current chunk finishes, next does not start.
    sendChunk(0);
    sendChunk(0);
    repeat (50) tick();
    enable_in = 1'b0;
    repeat (700) tick();
    check("enable_low_pending", sb.size(), 1);
    check("enable_low_busy", busy_out, 0);
    enable_in = 1'b1;
    drain();
    checkTotals("enable");

    // Zero seed behaves as seed 1.
    doResync(64'd0);
    sendChunk(0);
    sendChunk(0);
    drain();
    checkTotals("zeroseed");

    // Random seed with random corruption.
    doResync({32'($urandom), 32'($urandom)});
    sendChunk(2);
    drain();
    checkTotals("randseed");

    // Resync mid-chunk: no ack follows, pointer/counters cleared.
    sendChunk(1);
    waitOffset(200);
    doResync({32'($urandom), 32'($urandom)});
    repeat (600) tick();
    check("resync_mid_busy", busy_out, 0);
    sendChunk(0);
    drain();
    checkTotals("postresync");

    // Asynchronous reset mid-chunk.
    sendChunk(0);
    waitOffset(100);
    seed_in = {32'($urandom), 32'($urandom)};
    #2 pcieRstN_in = 1'b0;
    modelClear(64'h1);
    #1 checkIdle("async_rst");
    @(posedge pcieClk_in); #3 pcieRstN_in = 1'b1;
    tick();
    sendChunk(0);
    drain();
    checkTotals("postreset");

    // Saturation: 137 fully corrupted chunks = 70144 bad QWs.
    for (int i = 0; i < 137; i++) sendChunk(3);
    drain();
    check("sat_errCount", errCount_out, 16'hFFFF);
    check("sat_errFlag", errFlag_out, 1);
    check("sat_chunkCount", chunkCount_out, chunksSent);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/c2f_rng_checker.md
# c2f_rng_checker

- Consumer for the CPU->FPGA burst pipe.
- Drains chunks that the TLP transceiver writes into the C2F chunk RAM.
- Checks every QW against a locally regenerated 64-bit LFSR sequence. This is the same sequence the CPU host echoes back from the FPGA->CPU stream.
- Reports mismatches and releases each chunk back to the transceiver.
- Sits beside the chunk RAM in place of the example consumer, in bench and loopback images.

## Interface
Parameters:
- PTR_NBITS, 2, chunk-pointer width; 2^PTR_NBITS chunks in the ring.
- OFFSET_NBITS, 9, QW-offset width within a chunk; a chunk is 2^OFFSET_NBITS QWs (default 4 KiB).

Ports:
- pcieClk_in  in  1  the one and only clock, 125MHz PCIe clock.
- pcieRstN_in  in  1  reset: asynchronous assert, active-low.
- wrPtr_in  in  PTR_NBITS  producer write pointer; index of the next chunk the transceiver will fill.
- rdPtr_out  out  PTR_NBITS  consumer pointer; chunk being checked or next to check.
- rdOffset_out  out  OFFSET_NBITS  QW read address into the RAM, paired with rdPtr_out.
- rdData_in  in  64  RAM read data; registered, 1-cycle latency.
- dtAck_out  out  1  one-cycle pulse when a chunk is released.
- enable_in  in  1  permits starting a new chunk.
- resync_in  in  1  synchronous: reload LFSR from seed_in, zero pointer and counters.
- seed_in  in  64  LFSR seed; all-zero is replaced by 64'h1.
- errCount_out  out  16  mismatched QWs; saturates at 16'hFFFF.
- chunkCount_out  out  32  chunks released; wraps.
- errFlag_out  out  1  sticky, set on first mismatch.
- busy_out  out  1  high in any state other than S_IDLE.

## Operation
- LFSR, Galois, right-shift:
  - next = (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 0).
  - Expected QW is the current state s; the LFSR advances once per compared QW.
- FSM states:
  - S_IDLE: when enable_in and rdPtr_out != wrPtr_in, drive rdOffset_out=0, go to S_CHECK.
  - S_CHECK, address side: each cycle, increment rdOffset_out until all-ones.
  - S_CHECK, data side: a compare-valid pipeline bit qualifies rdData_in one cycle after each address.
  - S_CHECK, exit: after the compare for offset all-ones, go to S_RELEASE.
  - S_RELEASE: rdPtr_out += 1 (wraps modulo 2^PTR_NBITS), dtAck_out=1, chunkCount_out += 1, go to S_IDLE.
  - S_HALT: exists only with the macro (see Configuration).
- Compare: when valid and rdData_in != expected:
  - errCount_out increments, saturating.
  - errFlag_out is set.
- Full/empty:
  - Empty is rdPtr_out == wrPtr_in.
  - Full is the transceiver's concern; the checker only reads.
  - wrPtr_in advancing mid-chunk has no effect until S_IDLE.
- enable_in low mid-chunk: the current chunk completes; no new chunk starts.
- resync_in has priority over everything, in any state:
  - Next cycle: state S_IDLE, LFSR=seed (or 1), rdPtr_out=0, rdOffset_out=0.
  - errCount_out=0, chunkCount_out=0, errFlag_out=0.
  - No dtAck_out pulse; the compare pipeline is flushed.

## Timing
- Reset values:
  - rdPtr_out=0, rdOffset_out=0, dtAck_out=0.
  - errCount_out=0, chunkCount_out=0, errFlag_out=0, busy_out=0.
  - state S_IDLE; LFSR=64'h1 (seed_in is not sampled by reset).
- Reset mid-chunk: all of the above are applied immediately (asynchronously); nothing completes.
- Chunk cycle count:
  - Cycle 0: S_IDLE detects non-empty.
  - Cycles 1..2^OFFSET_NBITS: addresses issued.
  - One extra cycle for the final compare.
  - S_RELEASE cycle: dtAck_out high, rdPtr_out updates at its end.
  - Total from S_IDLE detect to dtAck_out is 2^OFFSET_NBITS+2 cycles.
- Back-to-back chunks: at most one S_IDLE cycle between chunks, so the minimum period is 2^OFFSET_NBITS+3 cycles.
- errCount_out/errFlag_out update the cycle after the offending data is presented on rdData_in.

## Configuration
- Macro: C2F_CHECKER_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch moves the FSM to S_HALT at the same edge errFlag_out sets.
  - S_HALT: rdOffset_out and rdPtr_out frozen, no dtAck_out, busy_out=1, errCount_out=1.
  - Only resync_in or reset exits S_HALT.
  - Leaves the failing chunk and offset observable.
- Undefined:
  - No S_HALT state.
  - Mismatches are counted and checking continues through every chunk.

## Test plan
- Clean chunk:
  - Stimulus: seed 64'h1; chunk 0 filled with 512 LFSR values; wrPtr_in 0->1; enable_in=1.
  - Response: dtAck_out pulse exactly 514 cycles after detect; rdPtr_out=1; chunkCount_out=1; errCount_out=0.
- Single corruption:
  - Stimulus: QW 37 of chunk 0 XOR 64'h1.
  - Response: errCount_out=1, errFlag_out=1.
  - Without the macro: dtAck_out still pulses.
  - With the macro: FSM holds in S_HALT, rdPtr_out=0, rdOffset_out frozen, no dtAck_out.
- Ring wrap:
  - Stimulus: 5 clean chunks with PTR_NBITS=2.
  - Response: rdPtr_out sequence 1,2,3,0,1; chunkCount_out=5; LFSR continuous across chunk boundaries.
- Zero seed:
  - Stimulus: resync_in with seed_in=0; data generated from seed 1.
  - Response: errCount_out=0.
- Resync mid-chunk:
  - Stimulus: resync_in asserted at offset 200.
  - Response: next cycle state S_IDLE, rdPtr_out=0, counters 0, no dtAck_out.
- Async reset and saturation:
  - Stimulus: pcieRstN_in low mid-chunk.
  - Response: all outputs at reset values before the next clock edge.
  - Stimulus: separately, 70000 corrupted QWs.
  - Response: errCount_out holds 16'hFFFF.
